// File: rtl/pwm_if.sv
// PWM control bundle: duty in from the controller, PWM waveform back out.
// Purely a wiring bundle; no state, no backpressure (duty is sampled every clock).
interface pwm_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] duty;
  logic             PWM_sig;

  modport master (output duty, input  PWM_sig);
  modport slave  (input  duty, output PWM_sig);
endinterface

// File: rtl/pwm.sv
// Free-running PWM: period 2^WIDTH clocks, high while cnt < duty; output is a flop, 1-clock latency.
// No backpressure: duty is sampled on every edge, so changes act on the very next comparison.
module pwm #(
  parameter int WIDTH = 10
) (
  input  logic  clk,
  input  logic  rst_n,
  pwm_if.slave  bus
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             pwm_q, pwm_d;

  // Natural wrap of the WIDTH-bit counter gives an exact 2^WIDTH period.
  always_comb begin
    cnt_d = cnt_q + WIDTH'(1'b1);
    pwm_d = (cnt_q < bus.duty);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
    end
  end

  assign bus.PWM_sig = pwm_q;

endmodule

// File: tb/tb_pwm.sv
// Randomized self-checking bench for pwm against a time-since-reset reference model.
module tb_pwm;
  localparam int W = 10;
  localparam int P = 1 << W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_if #(.WIDTH(W)) bus ();
  pwm #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  // Reference: the waveform is a function of edges elapsed since reset release and current duty.
  int  since_rst = 0;
  bit  model_ok  = 1'b0;
  bit  exp_pwm   = 1'b0;
  int  exp_cnt   = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      since_rst = 0;
      exp_pwm   = 1'b0;
      model_ok  = 1'b1;
    end else if (model_ok) begin
      exp_pwm   = ((since_rst % P) < int'(bus.duty));
      since_rst = since_rst + 1;
    end
    exp_cnt = since_rst % P;
  end

  // Per-window statistics gathered while the clock runs.
  int hi_cnt, rises, falls, mism;
  bit prev_pwm;

  task automatic clear_stats();
    hi_cnt = 0; rises = 0; falls = 0; mism = 0;
    prev_pwm = bus.PWM_sig;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (model_ok && (bus.PWM_sig !== exp_pwm || int'(dut.cnt_q) != exp_cnt)) mism++;
      if (bus.PWM_sig === 1'b1) hi_cnt++;
      if (bus.PWM_sig === 1'b1 && !prev_pwm) rises++;
      if (bus.PWM_sig === 1'b0 && prev_pwm) falls++;
      prev_pwm = (bus.PWM_sig === 1'b1);
    end
  endtask

  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    run_cycles(n);
    rst_n = 1'b1;
    clear_stats();
  endtask

  task automatic test_reset();
    bus.duty = 10'd512;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.PWM_sig !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_pwm cycle %0d: got %b expected 0", i, bus.PWM_sig);
      end
      n_checks++;
      if (dut.cnt_q !== 10'd0) begin
        n_errors++;
        $display("FAIL reset_cnt cycle %0d: got %0d expected 0", i, dut.cnt_q);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_mid_duty();
    bus.duty = 10'd512;
    apply_reset(1);
    run_cycles(1);
    n_checks++;
    if (bus.PWM_sig !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_first_rise: got %b expected 1", bus.PWM_sig);
    end
    run_cycles(2047);
    n_checks++;
    if (hi_cnt != 1024 || rises != 2 || falls != 2 || mism != 0) begin
      n_errors++;
      $display("FAIL mid_duty: high=%0d rises=%0d falls=%0d mism=%0d expected 1024/2/2/0",
               hi_cnt, rises, falls, mism);
    end
  endtask

  task automatic test_extremes();
    int d_tab [3] = '{0, 1023, 1};
    foreach (d_tab[k]) begin
      bus.duty = W'(d_tab[k]);
      apply_reset(1);
      run_cycles(3072);
      n_checks++;
      if (hi_cnt != 3 * d_tab[k] || rises != (d_tab[k] == 0 ? 0 : 3) || mism != 0) begin
        n_errors++;
        $display("FAIL extreme_duty_%0d: high=%0d rises=%0d mism=%0d expected %0d/%0d/0",
                 d_tab[k], hi_cnt, rises, mism, 3 * d_tab[k], (d_tab[k] == 0 ? 0 : 3));
      end
    end
  endtask

  task automatic test_duty_change(input int d0, input int at_cnt, input int d1);
    int exp_hi;
    bus.duty = W'(d0);
    apply_reset(1);
    run_cycles(at_cnt);
    n_checks++;
    if (int'(dut.cnt_q) != at_cnt) begin
      n_errors++;
      $display("FAIL change_cnt: got %0d expected %0d", dut.cnt_q, at_cnt);
    end
    bus.duty = W'(d1);
    run_cycles(P - at_cnt);
    exp_hi = (d1 > at_cnt) ? d1 : ((d0 < at_cnt) ? d0 : at_cnt);
    n_checks++;
    if (hi_cnt != exp_hi || rises != 1 || falls != 1 || mism != 0) begin
      n_errors++;
      $display("FAIL duty_change_%0d_to_%0d: high=%0d rises=%0d falls=%0d mism=%0d expected %0d/1/1/0",
               d0, d1, hi_cnt, rises, falls, mism, exp_hi);
    end
  endtask

  task automatic test_reset_midop(input int at_cnt);
    bus.duty = 10'd300;
    apply_reset(1);
    run_cycles(at_cnt);
    rst_n = 1'b0;
    run_cycles(1);
    n_checks++;
    if (bus.PWM_sig !== 1'b0 || dut.cnt_q !== 10'd0) begin
      n_errors++;
      $display("FAIL reset_midop_%0d: pwm=%b cnt=%0d expected 0/0", at_cnt, bus.PWM_sig, dut.cnt_q);
    end
    rst_n = 1'b1;
    clear_stats();
    run_cycles(P);
    n_checks++;
    if (hi_cnt != 300 || rises != 1 || mism != 0) begin
      n_errors++;
      $display("FAIL after_reset_midop_%0d: high=%0d rises=%0d mism=%0d expected 300/1/0",
               at_cnt, hi_cnt, rises, mism);
    end
  endtask

  task automatic test_random_steady();
    int d;
    for (int k = 0; k < 4; k++) begin
      d = $urandom_range(1, P - 2);
      bus.duty = W'(d);
      apply_reset(1);
      run_cycles(2 * P);
      n_checks++;
      if (hi_cnt != 2 * d || rises != 2 || falls != 2 || mism != 0) begin
        n_errors++;
        $display("FAIL random_steady_%0d: high=%0d rises=%0d falls=%0d mism=%0d expected %0d/2/2/0",
                 d, hi_cnt, rises, falls, mism, 2 * d);
      end
    end
  endtask

  task automatic test_random_churn();
    apply_reset(1);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) bus.duty = W'($urandom);
      rst_n = ($urandom_range(0, 499) != 0);
      run_cycles(1);
    end
    rst_n = 1'b1;
    n_checks++;
    if (mism != 0) begin
      n_errors++;
      $display("FAIL random_churn: mism=%0d expected 0", mism);
    end
  endtask

  initial begin
    bus.duty = '0;
    @(negedge clk);
    test_reset();
    test_mid_duty();
    test_extremes();
    test_duty_change(100, 50, 800);
    test_duty_change(800, 300, 200);
    test_reset_midop(700);
    test_reset_midop(100);
    test_random_steady();
    test_random_churn();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
